// File: rtl/timer_bank.sv
// Bank of NCH independent down-counting timers behind a small register window.
// Each channel has CTRL/PRESET/COUNT registers, a 4-state sequencer and a maskable irq.

module timer_ch #(
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_ctrl,
    input  logic          wr_preset,
    input  logic [CW-1:0] wd,
    output logic [4:0]    ctrl,
    output logic [CW-1:0] preset,
    output logic [CW-1:0] count,
    output logic          irq
);
    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

    state_t        state, state_nxt;
    logic          en, im, pend;
    logic [1:0]    mode;
    logic [CW-1:0] count_nxt;
    logic          pend_set, en_clr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        pend_set  = 1'b0;
        en_clr    = 1'b0;
        case (state)
            IDLE: if (en) state_nxt = LOAD;
            LOAD: begin
                count_nxt = preset;
                state_nxt = CNT;
            end
            CNT: begin
                if (!en) begin
                    state_nxt = IDLE;
                end else if (count <= CW'(1)) begin
                    count_nxt = '0;
                    pend_set  = 1'b1;
                    state_nxt = INT;
                end else begin
                    count_nxt = count - CW'(1);
                end
            end
            INT: begin
                // MODE 1x falls through to one-shot behaviour
                if (mode == 2'b01) begin
                    state_nxt = LOAD;
                end else begin
                    en_clr    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Hardware actions (EN clear, PEND set) win over a same-edge software write
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en     <= 1'b0;
            mode   <= 2'b00;
            im     <= 1'b0;
            pend   <= 1'b0;
            preset <= '0;
            count  <= '0;
        end else begin
            count <= count_nxt;
            if (wr_ctrl) begin
                en   <= wd[0] & ~en_clr;
                mode <= wd[2:1];
                im   <= wd[3];
            end else if (en_clr) begin
                en <= 1'b0;
            end
            if (pend_set)             pend <= 1'b1;
            else if (wr_ctrl && wd[4]) pend <= 1'b0;
            if (wr_preset) preset <= wd;
        end
    end

    assign ctrl = {pend, im, mode, en};
    assign irq  = pend & im;
endmodule

module timer_bank #(
    parameter int NCH = 2,
    parameter int CW  = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [6:0]     addr,
    input  logic           we,
    input  logic [31:0]    wdata,
    output logic [31:0]    rdata,
    output logic [NCH-1:0] irq,
    output logic           irq_any
);
    logic [2:0]                ch_sel;
    logic [1:0]                reg_sel;
    logic [NCH-1:0][4:0]       ctrl_v;
    logic [NCH-1:0][CW-1:0]    preset_v;
    logic [NCH-1:0][CW-1:0]    count_v;
    logic                      unused_bits;

    assign ch_sel      = addr[6:4];
    assign reg_sel     = addr[3:2];
    assign unused_bits = ^{addr[1:0], wdata};

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        timer_ch #(.CW(CW)) u_ch (
            .clk       (clk),
            .reset     (reset),
            .wr_ctrl   (we && ch_sel == 3'(g) && reg_sel == 2'd0),
            .wr_preset (we && ch_sel == 3'(g) && reg_sel == 2'd1),
            .wd        (wdata[CW-1:0]),
            .ctrl      (ctrl_v[g]),
            .preset    (preset_v[g]),
            .count     (count_v[g]),
            .irq       (irq[g])
        );
    end

    // Channels beyond NCH and the reserved slot fall through to zero
    always_comb begin
        rdata = '0;
        for (int i = 0; i < NCH; i++) begin
            if (ch_sel == 3'(i)) begin
                case (reg_sel)
                    2'd0:    rdata = 32'(ctrl_v[i]);
                    2'd1:    rdata = 32'(preset_v[i]);
                    2'd2:    rdata = 32'(count_v[i]);
                    default: rdata = '0;
                endcase
            end
        end
    end

    assign irq_any = |irq;
endmodule

// File: tb/tb_timer_bank.sv
// Random + directed bench for timer_bank against a per-channel behavioural model.
module tb_timer_bank;
    localparam int NCH = 2;
    localparam int CW  = 16;
    localparam logic [31:0] CMASK = 32'h0000_FFFF;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           we = 1'b0;
    logic [6:0]     addr = '0;
    logic [31:0]    wdata = '0;
    logic [31:0]    rdata;
    logic [NCH-1:0] irq;
    logic           irq_any;

    timer_bank #(.NCH(NCH), .CW(CW)) dut (
        .clk(clk), .reset(reset), .addr(addr), .we(we), .wdata(wdata),
        .rdata(rdata), .irq(irq), .irq_any(irq_any)
    );

    always #50 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: registers plus "where in the sequence" flags
    bit          m_en[NCH], m_im[NCH], m_pend[NCH];
    bit [1:0]    m_mode[NCH];
    int unsigned m_preset[NCH], m_count[NCH];
    bit          m_idle[NCH], m_load_due[NCH], m_int_due[NCH];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_en[i] = 0; m_im[i] = 0; m_pend[i] = 0; m_mode[i] = 0;
            m_preset[i] = 0; m_count[i] = 0;
            m_idle[i] = 1; m_load_due[i] = 0; m_int_due[i] = 0;
        end
    endtask

    task automatic model_edge(input bit w, input logic [6:0] a, input logic [31:0] d);
        for (int i = 0; i < NCH; i++) begin
            bit set_p = 0;
            bit clr_en = 0;
            bit wr_c, wr_p;
            if (m_idle[i]) begin
                if (m_en[i]) begin m_idle[i] = 0; m_load_due[i] = 1; end
            end else if (m_load_due[i]) begin
                m_count[i] = m_preset[i];
                m_load_due[i] = 0;
            end else if (m_int_due[i]) begin
                m_int_due[i] = 0;
                if (m_mode[i] == 2'b01) m_load_due[i] = 1;
                else begin clr_en = 1; m_idle[i] = 1; end
            end else if (!m_en[i]) begin
                m_idle[i] = 1;
            end else if (m_count[i] <= 1) begin
                m_count[i] = 0; set_p = 1; m_int_due[i] = 1;
            end else begin
                m_count[i] = m_count[i] - 1;
            end
            wr_c = w && (a[6:4] == i) && (a[3:2] == 0);
            wr_p = w && (a[6:4] == i) && (a[3:2] == 1);
            if (wr_c) begin
                m_en[i] = d[0] && !clr_en; m_mode[i] = d[2:1]; m_im[i] = d[3];
            end else if (clr_en) m_en[i] = 0;
            if (set_p) m_pend[i] = 1;
            else if (wr_c && d[4]) m_pend[i] = 0;
            if (wr_p) m_preset[i] = d & CMASK;
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [6:0] a);
        int c = a[6:4];
        int r = a[3:2];
        if (c >= NCH) return 0;
        case (r)
            0: return {27'd0, m_pend[c], m_im[c], m_mode[c], m_en[c]};
            1: return m_preset[c];
            2: return m_count[c];
            default: return 0;
        endcase
    endfunction

    task automatic compare_all(input string tag);
        logic [31:0] ei = 0;
        for (int a = 0; a < (NCH + 1) * 4; a++) begin
            addr = 7'(a * 4);
            #1;
            chk($sformatf("%s rd%02h", tag, a * 4), rdata, exp_rd(addr));
        end
        for (int i = 0; i < NCH; i++) ei[i] = m_pend[i] & m_im[i];
        chk({tag, " irq"}, 32'(irq), ei);
        chk({tag, " irq_any"}, 32'(irq_any), 32'(ei != 0));
    endtask

    task automatic rd(input logic [6:0] a, output logic [31:0] v);
        addr = a;
        #1;
        v = rdata;
    endtask

    task automatic step(input bit w, input logic [6:0] a, input logic [31:0] d);
        we = w; addr = a; wdata = d;
        @(posedge clk);
        model_edge(w, a, d);
        #1 we = 0;
        @(negedge clk);
        compare_all("step");
    endtask

    task automatic do_reset();
        reset = 0;
        model_reset();
        #1;
        compare_all("rst");
        @(negedge clk);
        reset = 1;
    endtask

    logic [31:0] v, d;
    logic [6:0]  a;
    bit          w;

    initial begin
        do_reset();

        // one-shot, PRESET=5: COUNT 5..0, irq after edge 7, EN self-clears
        step(1, 7'h04, 32'd5);
        step(1, 7'h00, 32'h9);
        for (int e = 1; e <= 8; e++) begin
            step(0, 7'h00, 0);
            if (e >= 2 && e <= 7) begin
                rd(7'h08, v); chk($sformatf("s1 count e%0d", e), v, 32'(7 - e));
            end
            if (e == 6) chk("s1 irq0 early", 32'(irq[0]), 0);
            if (e == 7) chk("s1 irq0", 32'(irq[0]), 1);
            if (e == 8) begin rd(7'h00, v); chk("s1 ctrl", v, 32'h18); end
        end

        // auto-reload ch1, PRESET=3: PEND at 5,10,15 with W1C in between
        do_reset();
        step(1, 7'h14, 32'd3);
        step(1, 7'h10, 32'hB);
        for (int e = 1; e <= 15; e++) begin
            step(e == 7 || e == 12, 7'h10, 32'h1B);
            if (e == 4 || e == 7 || e == 9 || e == 12 || e == 14)
                chk($sformatf("s2 irq1 low e%0d", e), 32'(irq[1]), 0);
            if (e == 5 || e == 10 || e == 15)
                chk($sformatf("s2 irq1 high e%0d", e), 32'(irq[1]), 1);
        end

        // PRESET=0 with IM=0, then PRESET=1 with IM=1: both expire at edge 3
        do_reset();
        step(1, 7'h04, 32'd0);
        step(1, 7'h00, 32'h1);
        for (int e = 1; e <= 3; e++) begin
            step(0, 7'h00, 0);
            if (e == 2) begin rd(7'h00, v); chk("s3 ctrl e2", v, 32'h01); end
            if (e == 3) begin
                rd(7'h00, v); chk("s3 ctrl e3", v, 32'h11);
                chk("s3 irq masked", 32'(irq), 0);
                chk("s3 irq_any masked", 32'(irq_any), 0);
            end
        end
        step(1, 7'h14, 32'd1);
        step(1, 7'h10, 32'h9);
        for (int e = 1; e <= 3; e++) begin
            step(0, 7'h00, 0);
            if (e == 2) chk("s3 irq1 e2", 32'(irq[1]), 0);
            if (e == 3) begin
                chk("s3 irq1 e3", 32'(irq[1]), 1);
                chk("s3 irq_any e3", 32'(irq_any), 1);
            end
        end

        // same-edge races: W1C vs expiry, EN write vs one-shot EN clear
        do_reset();
        step(1, 7'h04, 32'd2);
        step(1, 7'h00, 32'h9);
        for (int e = 1; e <= 5; e++) begin
            step(e >= 4, 7'h00, (e == 4) ? 32'h19 : 32'h9);
            if (e == 4) begin rd(7'h00, v); chk("s4 pend kept", v, 32'h19); end
            if (e == 5) begin rd(7'h00, v); chk("s4 en cleared", v, 32'h18); end
        end

        // asynchronous reset mid-count
        do_reset();
        step(1, 7'h04, 32'd5);
        step(1, 7'h00, 32'h9);
        for (int e = 1; e <= 5; e++) step(0, 7'h00, 0);
        rd(7'h08, v); chk("s5 count before", v, 2);
        reset = 0;
        model_reset();
        rd(7'h00, v); chk("s5 ctrl async", v, 0);
        rd(7'h04, v); chk("s5 preset async", v, 0);
        rd(7'h08, v); chk("s5 count async", v, 0);
        chk("s5 irq async", 32'(irq), 0);
        chk("s5 irq_any async", 32'(irq_any), 0);
        rd(7'h70, v); chk("s5 rd 0x70", v, 0);
        @(negedge clk);
        reset = 1;
        for (int e = 0; e < 4; e++) step(0, 7'h00, 0);

        // randomized traffic, including out-of-range channels and reserved slots
        for (int n = 0; n < 600; n++) begin
            w = ($urandom_range(0, 2) == 0);
            a = 7'(($urandom_range(0, 2) << 4) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
            d = $urandom;
            if (a[3:2] == 2'd1) d = (d & 32'hFFFF_0000) | $urandom_range(0, 6);
            step(w, a, d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/timer_bank.md
TIMER_BANK -- requirements
Module: timer_bank

Interface
REQ-001 SHALL have parameter NCH, default 2, number of independent timer channels (1..8).
REQ-002 SHALL have parameter CW, default 32, counter/preset width in bits (8..32).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port addr  input  7  byte address; addr[6:4] selects channel, addr[3:2] selects register, addr[1:0] ignored.
REQ-006 SHALL have port we  input  1  write strobe, sampled on the rising edge of clk.
REQ-007 SHALL have port wdata  input  32  write data.
REQ-008 SHALL have port rdata  output  32  combinational read data for addr.
REQ-009 SHALL have port irq  output  NCH  per-channel interrupt request.
REQ-010 SHALL have port irq_any  output  1  OR of all irq bits.

Function
REQ-011 SHALL map per channel: reg 0 = CTRL (R/W), reg 1 = PRESET (R/W, CW bits), reg 2 = COUNT (read-only), reg 3 = reserved (reads 0, writes ignored).
REQ-012 SHALL define CTRL bits: [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as one-shot), [3] IM interrupt mask, [4] PEND; bits [31:5] read 0.
REQ-013 SHALL treat CTRL[4] on write as write-1-to-clear of PEND; writing 0 leaves PEND unchanged.
REQ-014 SHALL zero-extend PRESET/COUNT reads above CW and truncate wdata to CW on PRESET write.
REQ-015 SHALL read 0 and ignore writes for channel index >= NCH and for writes to COUNT.
REQ-016 SHALL run per channel an FSM with states IDLE, LOAD, CNT, INT.
REQ-017 IDLE: if EN=1 go LOAD; else stay; COUNT holds.
REQ-018 LOAD: COUNT <= PRESET; go CNT.
REQ-019 CNT: if EN=0 go IDLE with COUNT held; else if COUNT <= 1 then COUNT <= 0, PEND <= 1, go INT; else COUNT <= COUNT-1.
REQ-020 INT: MODE one-shot -> EN <= 0, go IDLE; MODE auto-reload -> go LOAD.
REQ-021 SHALL give first-interrupt latency: CTRL write enabling EN at edge 0 sets PEND at edge max(PRESET,1)+2.
REQ-022 SHALL give auto-reload period of max(PRESET,1)+2 cycles between PEND-set edges.
REQ-023 SHALL drive irq[i] = PEND[i] & IM[i]; irq_any = |irq; both purely combinational from registers.
REQ-024 SHALL give hardware PEND-set priority over a same-edge W1C clear.
REQ-025 SHALL give FSM EN-clear in INT priority over a same-edge CTRL write setting EN (EN ends 0).
REQ-026 SHALL apply a PRESET write during CNT only at the next LOAD; the running COUNT is unaffected.
REQ-027 SHALL, on CTRL write with EN=0 during CNT, stop at the next edge with COUNT frozen; re-enabling reloads from PRESET via LOAD.
REQ-028 SHALL keep channels fully independent; a write affects only the addressed channel.

Reset
REQ-029 SHALL, while reset=0, asynchronously force all CTRL, PRESET, COUNT to 0, every FSM to IDLE, irq and irq_any to 0.
REQ-030 SHALL, on reset assertion mid-count, abandon counting and lose pending interrupts; after release nothing runs until EN is written.

Verification
REQ-031 SHALL cover: ch0 PRESET=5, CTRL=0x9 (EN, one-shot, IM) at edge 0 -> COUNT 5,4,3,2,1,0; irq[0]=1 after edge 7; CTRL reads 0x18 (EN cleared).
REQ-032 SHALL cover: ch1 PRESET=3, CTRL=0xB (auto-reload) -> PEND sets at edges 5, 10, 15; W1C write 0x1B between clears irq[1] until next expiry.
REQ-033 SHALL cover: PRESET=0 and PRESET=1 -> both set PEND at edge 3; IM=0 -> PEND=1 but irq=0, irq_any=0.
REQ-034 SHALL cover: W1C clear on the same edge as expiry -> PEND stays 1; CTRL EN write on the same edge one-shot INT clears EN -> EN reads 0.
REQ-035 SHALL cover: reset pulsed low mid-count (COUNT=2) -> all registers read 0, irq=0 immediately without clock; read of addr 0x70 with NCH=2 -> rdata=0.
